// File: rtl/fetch_pkg.sv
// Shared constants, slot type and pointer-width helper for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

  // Index width of a ring of `value` entries; never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) width = i + 32'sd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/fetch_protocol_checker.sv
// Simulation-only watchdog on the instruction memory response channel.
module fetch_protocol_checker (
  input logic clock,
  input logic reset,
  input logic rsp_valid_i,
  input logic none_outstanding_i
);

  // A response with nothing outstanding means the memory broke the request/response pairing.
  rsp_without_request: assert property (@(posedge clock) disable iff (reset)
    !(rsp_valid_i && none_outstanding_i));

endmodule

// File: rtl/fetch_slot_fifo.sv
// Slot ring: tail reserves a slot per accepted request, fill writes returned data in order,
// head presents the oldest slot to decode. Pointers carry one extra wrap bit.
module fetch_slot_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic        fill_i,
  input  logic [31:0] fill_data_i,
  input  logic        pop_i,
  output logic [PW:0] occupancy_o,
  output logic [PW:0] pending_o,
  output logic        head_valid_o,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_instr_o
);

  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  fetch_slot_t slots_q [DEPTH];
  logic [PW:0] head_q, head_d;
  logic [PW:0] tail_q, tail_d;
  logic [PW:0] fill_q, fill_d;
  fetch_slot_t head_slot_s;

  assign occupancy_o  = tail_q - head_q;
  assign pending_o    = tail_q - fill_q;
  assign head_slot_s  = slots_q[head_q[PW-1:0]];
  assign head_valid_o = (occupancy_o != {(PW+1){1'b0}}) && head_slot_s.filled;
  assign head_pc_o    = head_slot_s.pc;
  assign head_instr_o = head_slot_s.instr;

  // Pointer next-state; a flush collapses head and fill onto tail.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    if (flush_i) begin
      head_d = tail_q;
      fill_d = tail_q;
    end else begin
      tail_d = push_i ? (tail_q + PTR_ONE) : tail_q;
      fill_d = fill_i ? (fill_q + PTR_ONE) : fill_q;
      head_d = pop_i  ? (head_q + PTR_ONE) : head_q;
    end
  end

  // Pointer and slot storage registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= {(PW+1){1'b0}};
      tail_q <= {(PW+1){1'b0}};
      fill_q <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '{pc: 32'h0, instr: NOP_INSTR, filled: 1'b0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      if (!flush_i && push_i) begin
        slots_q[tail_q[PW-1:0]] <= '{pc: push_pc_i, instr: NOP_INSTR, filled: 1'b0};
      end
      if (!flush_i && fill_i) begin
        slots_q[fill_q[PW-1:0]].instr  <= fill_data_i;
        slots_q[fill_q[PW-1:0]].filled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, drops wrong-path responses after a
// redirect and presents PC/instruction pairs to decode. Define FETCH_PERF_CNT_EN for perf counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  localparam int            PW      = clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW:0]   drop_cnt_q, drop_cnt_d;
  logic [PW:0]   occupancy_s, pending_s, outstanding_s;
  logic [PW+1:0] reserved_s;
  logic          req_fire_s, fill_s, pop_s, head_valid_s;
  logic [31:0]   head_pc_s, head_instr_s;

  // Outstanding counts every unreturned response, including ones already marked for discard.
  assign outstanding_s  = pending_s + drop_cnt_q;
  assign reserved_s     = {1'b0, occupancy_s} + {1'b0, drop_cnt_q};
  assign imem_req_valid = !reset && !redirect_valid && (reserved_s < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign pop_s          = head_valid_s && if_ready;

  assign if_valid   = head_valid_s;
  assign if_pc      = head_valid_s ? head_pc_s : 32'h0000_0000;
  assign if_instruc = head_valid_s ? head_instr_s : NOP_INSTR;

  // Response routing and discard bookkeeping; a redirect rebuilds the discard count from scratch.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    fill_s     = 1'b0;
    if (redirect_valid) begin
      drop_cnt_d = (imem_rsp_valid && (outstanding_s != {(PW+1){1'b0}})) ?
                   (outstanding_s - PTR_ONE) : outstanding_s;
    end else if (imem_rsp_valid && (drop_cnt_q != {(PW+1){1'b0}})) begin
      drop_cnt_d = drop_cnt_q - PTR_ONE;
    end else if (imem_rsp_valid && (pending_s != {(PW+1){1'b0}})) begin
      fill_s = 1'b1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // PC next-state: redirect target (word aligned) beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (req_fire_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and discard counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= {(PW+1){1'b0}};
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_slot_fifo #(.DEPTH(DEPTH)) u_slots (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .push_i       (req_fire_s),
    .push_pc_i    (pc_q),
    .fill_i       (fill_s),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop_s),
    .occupancy_o  (occupancy_s),
    .pending_o    (pending_s),
    .head_valid_o (head_valid_s),
    .head_pc_o    (head_pc_s),
    .head_instr_o (head_instr_s)
  );

  fetch_protocol_checker u_checker (
    .clock              (clock),
    .reset              (reset),
    .rsp_valid_i        (imem_rsp_valid),
    .none_outstanding_i (outstanding_s == {(PW+1){1'b0}})
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_redirect_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q    <= 32'h0;
      perf_redirect_q <= 32'h0;
    end else begin
      if (head_valid_s && !if_ready) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid) perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redirect_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model and a PC scoreboard.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready, if_valid;
  logic [31:0] if_pc, if_instruc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  always #5 clock = ~clock;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruc     (if_instruc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  int errors = 0, checks = 0, cyc = 0;
  int first_acc = -1, first_val = -1;
  int n_redirects = 0, n_stalls = 0;
  int na, np;
  bit hold = 1'b0;
  logic [31:0] model_pc;
  logic [31:0] exp_q[$], mem_q[$], acc_log[$], pop_log[$];
  logic [31:0] stall_pc, stall_ins;
  bit have_stall;

  // Memory content: a simple address-derived word, never equal to the NOP encoding.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + 32'h0000_0101;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update model, then drive the memory response for the next cycle.
  task automatic tick();
    logic acc, pop;
    @(negedge clock);
    acc = imem_req_valid && imem_req_ready;
    pop = if_valid && if_ready;
    if (!reset && if_valid && first_val < 0) first_val = cyc;
    if (!reset && if_valid && !if_ready) n_stalls++;
    if (pop) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed pc %h expected no instruction", if_pc);
      end
      if (exp_q.size() > 0) begin
        check("if_pc", if_pc, exp_q[0]);
        check("if_instruc", if_instruc, word_at(exp_q[0]));
        void'(exp_q.pop_front());
      end
      pop_log.push_back(if_pc);
    end
    if (!if_valid) check("bubble_nop", if_instruc, NOP_INSTR);
    if (acc) mem_q.push_back(imem_req_addr);
    if (redirect_valid) begin
      check("req_blocked_on_redirect", {31'h0, imem_req_valid}, 32'h0);
      model_pc = {redirect_pc[31:2], 2'b00};
      exp_q.delete();
      n_redirects++;
    end else if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      check("req_addr", imem_req_addr, model_pc);
      exp_q.push_back(model_pc);
      acc_log.push_back(imem_req_addr);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (!hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    hold           = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && (mem_q.size() == 0) && !imem_rsp_valid && !if_valid;
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d queued expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0; model_pc = 32'h0;
    tick();
    tick();
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instruc", if_instruc, NOP_INSTR);

    // Streaming from reset.
    reset = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (12) tick();
    check("first_fetch_latency", 32'(first_val - first_acc), 32'd2);
    check("stream_req0", q_at(acc_log, 0), 32'h0);
    check("stream_req1", q_at(acc_log, 1), 32'h4);
    check("stream_req2", q_at(acc_log, 2), 32'h8);
    check("stream_pop0", q_at(pop_log, 0), 32'h0);
    drain();

    // Decode stall: two slots fill, requests stop, head is held.
    redirect_to(32'h0000_0000);
    if_ready = 1'b0; imem_req_ready = 1'b1;
    na = acc_log.size(); np = pop_log.size(); have_stall = 1'b0;
    repeat (5) begin
      tick();
      if (if_valid && !have_stall) begin
        stall_pc = if_pc; stall_ins = if_instruc; have_stall = 1'b1;
      end else if (if_valid) begin
        check("stall_pc_stable", if_pc, stall_pc);
        check("stall_ins_stable", if_instruc, stall_ins);
      end
    end
    check("stall_accepts", 32'(acc_log.size() - na), 32'd2);
    check("stall_req_off", {31'h0, imem_req_valid}, 32'h0);
    check("stall_head_pc", stall_pc, 32'h0);
    if_ready = 1'b1;
    repeat (4) tick();
    check("stall_pop0", q_at(pop_log, np), 32'h0);
    check("stall_pop1", q_at(pop_log, np + 1), 32'h4);
    drain();

    // Redirect with two requests in flight and no response that cycle.
    hold = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
    na = acc_log.size();
    repeat (3) tick();
    check("inflight_two", 32'(acc_log.size() - na), 32'd2);
    na = acc_log.size(); np = pop_log.size();
    redirect_to(32'h0000_0103);
    check("drop_two", 32'(dut.drop_cnt_q), 32'd2);
    hold = 1'b0;
    repeat (10) tick();
    check("redir_req_addr", q_at(acc_log, na), 32'h0000_0100);
    check("redir_first_pop", q_at(pop_log, np), 32'h0000_0100);
    drain();

    // Redirect in the same cycle as a stale response.
    hold = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    tick();
    na = acc_log.size(); np = pop_log.size();
    redirect_to(32'h0000_0200);
    check("drop_one", 32'(dut.drop_cnt_q), 32'd1);
    repeat (10) tick();
    check("same_cyc_req_addr", q_at(acc_log, na), 32'h0000_0200);
    check("same_cyc_first_pop", q_at(pop_log, np), 32'h0000_0200);
    drain();

    // Memory refuses requests: bubbles only, address parked on the PC.
    repeat (10) begin
      tick();
      check("noready_if_valid", {31'h0, if_valid}, 32'h0);
      check("noready_nop", if_instruc, NOP_INSTR);
      check("noready_addr", imem_req_addr, model_pc);
    end

    // PC wraps past the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    na = acc_log.size();
    imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (4) tick();
    check("wrap_req0", q_at(acc_log, na), 32'hFFFF_FFFC);
    check("wrap_req1", q_at(acc_log, na + 1), 32'h0000_0000);
    drain();

`ifdef FETCH_PERF_CNT_EN
    check("perf_redirects", perf_redirects, 32'(n_redirects));
    check("perf_stall_cycles", perf_stall_cycles, 32'(n_stalls));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Owns the PC register and issues in-order requests to instruction memory.
- Buffers returned instructions in a DEPTH-entry slot FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from EX, discards wrong-path responses, and emits a NOP bubble when no instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, slot FIFO entries; also the maximum number of requests in flight (power of 2, ≥2).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  request address, word aligned.
- imem_rsp_valid  in  1  response valid; in order; arrives ≥1 cycle after its accept.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken, from EX.
- redirect_pc  in  32  new PC target.
- if_ready  in  1  decode can accept; low means stall.
- if_valid  out  1  if_pc/if_instruc hold a real instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instruc  out  32  instruction, or NOP_INSTR when if_valid=0.

Behaviour:
- Reset (synchronous, active-high):
  - pc_q=RESET_PC; FIFO empty; drop_cnt=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instruc=NOP_INSTR (32'h0000_0013).
- Instruction memory shares this reset; no responses arrive after reset.
- Slot reservation:
  - Request valid when occupancy + drop_cnt < DEPTH and redirect_valid=0.
  - imem_req_addr=pc_q.
  - On accept (valid && ready): write pc_q into the tail slot with filled=0, tail++, pc_q += 4 (modulo 2^32, wraps).
- Response handling:
  - If drop_cnt > 0: discard the response, drop_cnt--.
  - Otherwise: write data into the fill-pointer slot, set filled=1, fill++.
- Output:
  - if_valid = head slot occupied && filled.
  - Outputs are driven from registered slot state; no combinational path from imem_rsp_* or if_ready to the if_* outputs.
- Pop: when if_valid && if_ready, head++. Zero-cycle bypass is not required; minimum response-to-if_valid latency is 1 cycle.
- Stall: while if_ready=0, if_pc/if_instruc stay stable; requests continue until slots are exhausted.
- Redirect (highest priority):
  - pc_q ← {redirect_pc[31:2], 2'b00}.
  - FIFO cleared: head=tail=fill.
  - drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0), where outstanding = requested-but-unreturned responses, including prior drops.
  - The response arriving in the same cycle is discarded.
  - imem_req_valid=0 in the redirect cycle.
  - A pop in the same cycle is harmless; EX flushes the wrong-path instruction.
- Redirect on consecutive cycles: each redirect recomputes drop_cnt from its current state; the last target wins.
- Full: occupancy + drop_cnt = DEPTH → no request.
- Empty: if_valid=0, and if_instruc carries NOP_INSTR so IF/ID captures a bubble.
- Protocol violation: imem_rsp_valid with no outstanding request is ignored and flagged by a simulation assertion.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] (cycles with if_valid=1 && if_ready=0) and perf_redirects[31:0] (count of redirect_valid cycles).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant.
  - DEFAULT_RESET_PC constant.
  - fetch_slot_t struct {pc[31:0], instr[31:0], filled}.
  - Pointer-width function clog2(DEPTH).
- Sub-module fetch_slot_fifo holds the slot array with three pointers (tail/fill/head) and a flush input.
- The top level holds pc_q, drop_cnt, the request/redirect control, and the optional counters.

Test Plan:
- Reset then imem_req_ready=1, responses 1 cycle later, if_ready=1:
  - Requests go to 0x0, 0x4, 0x8, ….
  - if_pc=0x0 appears 2 cycles after the first accept, then one instruction per cycle.
- if_ready=0 for 5 cycles while responses return:
  - Exactly DEPTH=2 requests are accepted, then imem_req_valid=0.
  - if_pc/if_instruc are held stable.
  - After release, 0x0 and 0x4 are popped in order.
- redirect_valid with redirect_pc=0x103 while 2 requests are in flight:
  - Next request address is 0x100.
  - Both stale responses are discarded.
  - The first if_valid carries if_pc=0x100.
- redirect_valid in the same cycle as a response, with 2 in flight:
  - drop_cnt=1.
  - Only one further response is dropped.
  - The next response maps to the redirect target.
- imem_req_ready=0 for 10 cycles:
  - if_valid=0 and if_instruc=32'h0000_0013 throughout.
  - imem_req_addr stays at pc_q.
- pc_q=0xFFFF_FFFC accepted:
  - The next address is 0x0000_0000.
  - With FETCH_PERF_CNT_EN defined, perf_redirects increments once per redirect cycle.
